bus_arbiter_nm: RTL and testbench

Parametrised N-master bus arbiter with split-transaction support, for the serial master/slave bus fabric. It replaces the fixed two-master arbitration inside the current bus with a configurable master count and a selectable fixed-priority or round-robin policy. It tracks one outstanding split transaction and re-grants the split master with top priority when the slave signals completion. The bus decoder and muxes sit downstream and are steered by the one-hot grant and owner index.

---
 rtl/bus_arbiter_nm.sv | 119 +++++++++++
 tb/tb_bus_arbiter_nm.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_nm.sv
// N-master bus arbiter with fixed-priority or round-robin policy and one
// outstanding split transaction that is re-granted ahead of normal arbitration.
module bus_arbiter_nm #(
    parameter int NUM_MASTERS = 2,
    parameter int ARB_MODE = 1,
    localparam int MID_W = (NUM_MASTERS > 2) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] breq,
    input  logic                   sready,
    input  logic                   ssplit,
    input  logic                   split_done,
    output logic [NUM_MASTERS-1:0] bgrant,
    output logic [NUM_MASTERS-1:0] msplit,
    output logic [MID_W-1:0]       owner_id,
    output logic                   bus_busy,
    output logic                   split_busy,
    output logic                   split_grant
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]             state;
    logic [MID_W-1:0]       rr_ptr;
    logic [MID_W-1:0]       split_owner;
    logic                   resume;
    logic [NUM_MASTERS-1:0] split_mask;
    logic [NUM_MASTERS-1:0] eligible;
    logic [MID_W-1:0]       winner;
    logic                   found;

    function automatic logic [MID_W-1:0] inc_wrap(input logic [MID_W-1:0] x);
        return (x == MID_W'(NUM_MASTERS - 1)) ? '0 : x + 1'b1;
    endfunction

    assign split_mask = split_busy ? (NUM_MASTERS'(1) << split_owner) : '0;
    assign eligible   = breq & ~split_mask;
    assign bus_busy   = |bgrant;

    // Round-robin rotates the search origin; fixed priority always starts at 0.
    always_comb begin
        logic [MID_W-1:0] idx;
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (ARB_MODE == 1)
                idx = MID_W'((32'(rr_ptr) + i) % 32'(NUM_MASTERS));
            else
                idx = MID_W'(i);
            if (!found && eligible[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            bgrant      <= '0;
            msplit      <= '0;
            owner_id    <= '0;
            split_busy  <= 1'b0;
            split_grant <= 1'b0;
            rr_ptr      <= '0;
            split_owner <= '0;
            resume      <= 1'b0;
        end else begin
            split_grant <= 1'b0;
            if (split_done && split_busy)
                resume <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (resume && breq[split_owner]) begin
                        if (sready) begin
                            bgrant      <= NUM_MASTERS'(1) << split_owner;
                            owner_id    <= split_owner;
                            rr_ptr      <= inc_wrap(split_owner);
                            msplit      <= '0;
                            split_busy  <= 1'b0;
                            resume      <= 1'b0;
                            split_grant <= 1'b1;
                            state       <= ST_BUSY;
                        end
                    end else if (resume) begin
                        // Split master gave up its request: drop the split without a grant.
                        msplit     <= '0;
                        split_busy <= 1'b0;
                        resume     <= 1'b0;
                    end else if (sready && found) begin
                        bgrant   <= NUM_MASTERS'(1) << winner;
                        owner_id <= winner;
                        rr_ptr   <= inc_wrap(winner);
                        state    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (ssplit && !split_busy) begin
                        split_owner <= owner_id;
                        msplit      <= NUM_MASTERS'(1) << owner_id;
                        split_busy  <= 1'b1;
                        bgrant      <= '0;
                        owner_id    <= '0;
                        state       <= ST_IDLE;
                    end else if (!breq[owner_id]) begin
                        bgrant   <= '0;
                        owner_id <= '0;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter_nm.sv
// Bench for bus_arbiter_nm: fixed-priority and round-robin instances driven in
// parallel, table-driven vectors plus hand-written split/reset/RR sequences.
module tb_bus_arbiter_nm;

    typedef struct {
        logic [3:0] breq;
        logic       sr;
        logic       ss;
        logic       sd;
        logic [3:0] g;
        logic [3:0] ms;
        logic [1:0] own;
        logic       sb;
        logic       sg;
    } vec_t;

    typedef struct {
        int         step;
        bit         rr;
        logic [3:0] grant;
        logic [3:0] msplit;
        logic [1:0] owner;
        logic       sbusy;
        logic       sgrant;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] breq;
    logic       sready, ssplit, split_done;
    logic [3:0] fp_grant, fp_msplit, rr_grant, rr_msplit;
    logic [1:0] fp_owner, rr_owner;
    logic       fp_busy, fp_sbusy, fp_sgrant, rr_busy, rr_sbusy, rr_sgrant;

    int   checks = 0;
    int   errors = 0;
    vec_t vecs[34];
    exp_t sb_q[$];

    always #5 clk = ~clk;

    bus_arbiter_nm #(.NUM_MASTERS(4), .ARB_MODE(0)) dut_fp (
        .clk(clk), .rst(rst), .breq(breq), .sready(sready), .ssplit(ssplit),
        .split_done(split_done), .bgrant(fp_grant), .msplit(fp_msplit),
        .owner_id(fp_owner), .bus_busy(fp_busy), .split_busy(fp_sbusy),
        .split_grant(fp_sgrant)
    );

    bus_arbiter_nm #(.NUM_MASTERS(4), .ARB_MODE(1)) dut_rr (
        .clk(clk), .rst(rst), .breq(breq), .sready(sready), .ssplit(ssplit),
        .split_done(split_done), .bgrant(rr_grant), .msplit(rr_msplit),
        .owner_id(rr_owner), .bus_busy(rr_busy), .split_busy(rr_sbusy),
        .split_grant(rr_sgrant)
    );

    task automatic check(input string name, input int step, input logic [3:0] got,
                         input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %b expected %b", name, step, got, exp);
        end
    endtask

    task automatic check_all_zero(input int step);
        check("fp_bgrant_rst", step, fp_grant, 4'b0);
        check("fp_msplit_rst", step, fp_msplit, 4'b0);
        check("fp_owner_rst", step, {2'b0, fp_owner}, 4'b0);
        check("fp_busy_rst", step, {3'b0, fp_busy}, 4'b0);
        check("fp_sbusy_rst", step, {3'b0, fp_sbusy}, 4'b0);
        check("fp_sgrant_rst", step, {3'b0, fp_sgrant}, 4'b0);
        check("rr_bgrant_rst", step, rr_grant, 4'b0);
        check("rr_msplit_rst", step, rr_msplit, 4'b0);
        check("rr_owner_rst", step, {2'b0, rr_owner}, 4'b0);
        check("rr_busy_rst", step, {3'b0, rr_busy}, 4'b0);
        check("rr_sbusy_rst", step, {3'b0, rr_sbusy}, 4'b0);
        check("rr_sgrant_rst", step, {3'b0, rr_sgrant}, 4'b0);
    endtask

    task automatic compare_out();
        exp_t       e;
        logic [3:0] g, m;
        logic [1:0] o;
        logic       bb, sb, sg;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: got empty queue expected an entry");
            return;
        end
        e  = sb_q.pop_front();
        g  = e.rr ? rr_grant  : fp_grant;
        m  = e.rr ? rr_msplit : fp_msplit;
        o  = e.rr ? rr_owner  : fp_owner;
        bb = e.rr ? rr_busy   : fp_busy;
        sb = e.rr ? rr_sbusy  : fp_sbusy;
        sg = e.rr ? rr_sgrant : fp_sgrant;
        check("bgrant", e.step, g, e.grant);
        check("msplit", e.step, m, e.msplit);
        check("owner_id", e.step, {2'b0, o}, {2'b0, e.owner});
        check("bus_busy", e.step, {3'b0, bb}, {3'b0, |e.grant});
        check("split_busy", e.step, {3'b0, sb}, {3'b0, e.sbusy});
        check("split_grant", e.step, {3'b0, sg}, {3'b0, e.sgrant});
    endtask

    // Inputs are applied just after a rising edge; expectations describe the
    // registered outputs after the following edge.
    task automatic step_cycle(input logic [3:0] b, input logic sr, input logic ss,
                              input logic sd, input exp_t e);
        breq       = b;
        sready     = sr;
        ssplit     = ss;
        split_done = sd;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    initial begin
        exp_t e;
        // fixed priority: basic grant, turnaround, next lower-priority master
        vecs[0]  = '{4'b1010, 1'b1, 1'b0, 1'b0, 4'b0010, 4'b0000, 2'd1, 1'b0, 1'b0};
        vecs[1]  = '{4'b1010, 1'b1, 1'b0, 1'b0, 4'b0010, 4'b0000, 2'd1, 1'b0, 1'b0};
        vecs[2]  = '{4'b1000, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[3]  = '{4'b1000, 1'b1, 1'b0, 1'b0, 4'b1000, 4'b0000, 2'd3, 1'b0, 1'b0};
        vecs[4]  = '{4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
        // split master 2, master 0 served while 2 is masked
        vecs[5]  = '{4'b0100, 1'b1, 1'b0, 1'b0, 4'b0100, 4'b0000, 2'd2, 1'b0, 1'b0};
        vecs[6]  = '{4'b0100, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0100, 2'd0, 1'b1, 1'b0};
        vecs[7]  = '{4'b0101, 1'b1, 1'b0, 1'b0, 4'b0001, 4'b0100, 2'd0, 1'b1, 1'b0};
        vecs[8]  = '{4'b0101, 1'b1, 1'b0, 1'b0, 4'b0001, 4'b0100, 2'd0, 1'b1, 1'b0};
        // split_done during BUSY: no preemption, resume after release
        vecs[9]  = '{4'b0101, 1'b1, 1'b0, 1'b1, 4'b0001, 4'b0100, 2'd0, 1'b1, 1'b0};
        vecs[10] = '{4'b0101, 1'b1, 1'b0, 1'b0, 4'b0001, 4'b0100, 2'd0, 1'b1, 1'b0};
        vecs[11] = '{4'b0100, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0100, 2'd0, 1'b1, 1'b0};
        vecs[12] = '{4'b0100, 1'b1, 1'b0, 1'b0, 4'b0100, 4'b0000, 2'd2, 1'b0, 1'b1};
        vecs[13] = '{4'b0100, 1'b1, 1'b0, 1'b0, 4'b0100, 4'b0000, 2'd2, 1'b0, 1'b0};
        vecs[14] = '{4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
        // abandoned split for master 1
        vecs[15] = '{4'b0010, 1'b1, 1'b0, 1'b0, 4'b0010, 4'b0000, 2'd1, 1'b0, 1'b0};
        vecs[16] = '{4'b0010, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0010, 2'd0, 1'b1, 1'b0};
        vecs[17] = '{4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0010, 2'd0, 1'b1, 1'b0};
        vecs[18] = '{4'b0000, 1'b1, 1'b0, 1'b1, 4'b0000, 4'b0010, 2'd0, 1'b1, 1'b0};
        vecs[19] = '{4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[20] = '{4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
        // second ssplit ignored with simultaneous split_done; split master beats master 0
        vecs[21] = '{4'b1000, 1'b1, 1'b0, 1'b0, 4'b1000, 4'b0000, 2'd3, 1'b0, 1'b0};
        vecs[22] = '{4'b1000, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b1000, 2'd0, 1'b1, 1'b0};
        vecs[23] = '{4'b1001, 1'b1, 1'b0, 1'b0, 4'b0001, 4'b1000, 2'd0, 1'b1, 1'b0};
        vecs[24] = '{4'b1001, 1'b1, 1'b1, 1'b1, 4'b0001, 4'b1000, 2'd0, 1'b1, 1'b0};
        vecs[25] = '{4'b1000, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b1000, 2'd0, 1'b1, 1'b0};
        vecs[26] = '{4'b1001, 1'b1, 1'b0, 1'b0, 4'b1000, 4'b0000, 2'd3, 1'b0, 1'b1};
        vecs[27] = '{4'b0001, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[28] = '{4'b0001, 1'b1, 1'b0, 1'b0, 4'b0001, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[29] = '{4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
        // sready stalls IDLE grants but not an ongoing BUSY
        vecs[30] = '{4'b0001, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[31] = '{4'b0001, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[32] = '{4'b0001, 1'b1, 1'b0, 1'b0, 4'b0001, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[33] = '{4'b0001, 1'b0, 1'b0, 1'b0, 4'b0001, 4'b0000, 2'd0, 1'b0, 1'b0};

        rst = 1'b1;
        breq = 4'b0;
        sready = 1'b0;
        ssplit = 1'b0;
        split_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero(-1);
        rst = 1'b0;

        for (int i = 0; i < 34; i++) begin
            e = '{i, 1'b0, vecs[i].g, vecs[i].ms, vecs[i].own, vecs[i].sb, vecs[i].sg};
            step_cycle(vecs[i].breq, vecs[i].sr, vecs[i].ss, vecs[i].sd, e);
        end

        // asynchronous reset while BUSY, checked before any further clock edge
        #3 rst = 1'b1;
        #1;
        check_all_zero(-2);
        breq = 4'b0;
        sready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // round-robin: each owner holds 3 cycles, releases for one, re-requests
        for (int k = 0; k < 5; k++) begin
            logic [1:0] w;
            logic [3:0] oh;
            w  = 2'(k % 4);
            oh = 4'b0001 << w;
            for (int c = 0; c < 3; c++) begin
                e = '{100 + k * 4 + c, 1'b1, oh, 4'b0, w, 1'b0, 1'b0};
                step_cycle(4'b1111, 1'b1, 1'b0, 1'b0, e);
            end
            e = '{100 + k * 4 + 3, 1'b1, 4'b0, 4'b0, 2'd0, 1'b0, 1'b0};
            step_cycle(4'b1111 & ~oh, 1'b1, 1'b0, 1'b0, e);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
